// File: rtl/sub_xbit_serial_if.sv
// Request/response bundle for the slice-serial subtractor.
// Slave side is the subtractor, master side the requester/consumer.
interface sub_xbit_serial_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_num_a;
  logic [DATA_WIDTH-1:0] i_num_b;
  logic                  i_brw;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_res;
  logic                  o_brw;
  logic                  o_ovf;
  logic                  o_zero;

  modport slave (
    input  i_valid, i_num_a, i_num_b, i_brw, i_ready,
    output o_ready, o_valid, o_res, o_brw, o_ovf, o_zero
  );

  modport master (
    output i_valid, i_num_a, i_num_b, i_brw, i_ready,
    input  o_ready, o_valid, o_res, o_brw, o_ovf, o_zero
  );
endinterface

// File: rtl/sub_xbit_serial.sv
// Slice-serial subtractor: res = A - B - brw, SLICE_WIDTH bits per cycle.
// Operands shift right each cycle; result slices shift in from the top.
module sub_xbit_serial #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  sub_xbit_serial_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = SLICE_WIDTH;
  localparam int NUM_SLICES = DW / SW;
  localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  if (DW % SW != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of SLICE_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          brw_q, brw_d;
  logic [DW-1:0] wres_q, wres_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] res_q, res_d;
  logic          obrw_q, obrw_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [SW:0]   sub;
  logic [DW-1:0] dext;
  logic [DW-1:0] shifted;
  logic          last;

  always_comb begin
    sub = {1'b0, a_q[SW-1:0]}
        - {1'b0, b_q[SW-1:0]}
        - {{SW{1'b0}}, brw_q};
    dext = '0;
    dext[SW-1:0] = sub[SW-1:0];
    shifted = (wres_q >> SW) | (dext << (DW - SW));
    last = (cnt_q == CW'(NUM_SLICES - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    wres_d  = wres_q;
    valid_d = valid_q;
    res_d   = res_q;
    obrw_d  = obrw_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_num_a;
          b_d     = bus.i_num_b;
          brw_d   = bus.i_brw;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d    = a_q >> SW;
        b_d    = b_q >> SW;
        brw_d  = sub[SW];
        wres_d = shifted;
        if (last) begin
          // top slice still sits in the low bits: its msb is the operand msb
          res_d   = shifted;
          obrw_d  = sub[SW];
          ovf_d   = (a_q[SW-1] != b_q[SW-1])
                 && (shifted[DW-1] != a_q[SW-1]);
          zero_d  = (shifted == '0);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      wres_q  <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      obrw_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      wres_q  <= wres_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      obrw_q  <= obrw_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_res   = res_q;
  assign bus.o_brw   = obrw_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_zero  = zero_q;
endmodule
